// File: rtl/cpu_fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, keeps one I-cache request in flight,
// and presents fetched words to decode. Execute redirects override everything.
module cpu_fetch_sequencer #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    output logic                  o_icache_req_valid,
    input  logic                  i_icache_req_ready,
    output logic [ADDR_WIDTH-1:0] o_icache_req_addr,
    input  logic                  i_icache_rsp_valid,
    input  logic [31:0]           i_icache_rsp_word,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    input  logic                  i_stall,
    output logic                  o_decode_valid,
    output logic [31:0]           o_decode_instr,
    output logic [ADDR_WIDTH-1:0] o_decode_pc,
    output logic [ADDR_WIDTH-1:0] o_decode_next_pc
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

    state_t                r_state, w_state_d;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_d;
    logic [ADDR_WIDTH-1:0] r_req_pc, w_req_pc_d;
    logic                  r_dec_valid, w_dec_valid_d;
    logic [31:0]           r_dec_instr, w_dec_instr_d;
    logic [ADDR_WIDTH-1:0] r_dec_pc, w_dec_pc_d;
    logic [ADDR_WIDTH-1:0] r_dec_next_pc, w_dec_next_pc_d;

    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    logic [ADDR_WIDTH-1:0] w_req_pc_plus4;

    // Instructions are word aligned; low address bits of a redirect are dropped.
    assign w_redirect_pc  = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign w_req_pc_plus4 = r_req_pc + ADDR_WIDTH'(4);

    assign o_icache_req_valid = (r_state == S_REQ) && !i_redirect_valid;
    assign o_icache_req_addr  = r_pc;
    assign o_decode_valid     = r_dec_valid;
    assign o_decode_instr     = r_dec_instr;
    assign o_decode_pc        = r_dec_pc;
    assign o_decode_next_pc   = r_dec_next_pc;

    always_comb begin
        w_state_d       = r_state;
        w_pc_d          = r_pc;
        w_req_pc_d      = r_req_pc;
        w_dec_valid_d   = r_dec_valid;
        w_dec_instr_d   = r_dec_instr;
        w_dec_pc_d      = r_dec_pc;
        w_dec_next_pc_d = r_dec_next_pc;
        unique case (r_state)
            S_REQ: begin
                if (i_redirect_valid) begin
                    w_pc_d = w_redirect_pc;
                end else if (i_icache_req_ready) begin
                    w_req_pc_d = r_pc;
                    w_state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect_valid) begin
                    w_pc_d    = w_redirect_pc;
                    // An outstanding response must still be drained before re-requesting.
                    w_state_d = i_icache_rsp_valid ? S_REQ : S_DROP;
                end else if (i_icache_rsp_valid) begin
                    w_dec_valid_d   = 1'b1;
                    w_dec_instr_d   = i_icache_rsp_word;
                    w_dec_pc_d      = r_req_pc;
                    w_dec_next_pc_d = w_req_pc_plus4;
                    w_pc_d          = w_req_pc_plus4;
                    w_state_d       = S_HOLD;
                end
            end
            S_DROP: begin
                if (i_redirect_valid) begin
                    w_pc_d = w_redirect_pc;
                end
                if (i_icache_rsp_valid) begin
                    w_state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (i_redirect_valid) begin
                    w_dec_valid_d = 1'b0;
                    w_pc_d        = w_redirect_pc;
                    w_state_d     = S_REQ;
                end else if (!i_stall) begin
                    w_dec_valid_d = 1'b0;
                    w_state_d     = S_REQ;
                end
            end
            default: w_state_d = S_REQ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_REQ;
            r_pc          <= BOOT_ADDR;
            r_req_pc      <= '0;
            r_dec_valid   <= 1'b0;
            r_dec_instr   <= '0;
            r_dec_pc      <= '0;
            r_dec_next_pc <= '0;
        end else begin
            r_state       <= w_state_d;
            r_pc          <= w_pc_d;
            r_req_pc      <= w_req_pc_d;
            r_dec_valid   <= w_dec_valid_d;
            r_dec_instr   <= w_dec_instr_d;
            r_dec_pc      <= w_dec_pc_d;
            r_dec_next_pc <= w_dec_next_pc_d;
        end
    end

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Directed bench for cpu_fetch_sequencer: inputs change just after posedge,
// outputs are compared on the following negedge against hand-computed values.
module tb_cpu_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_word;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        stall;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_next_pc;

    int checks = 0;
    int errors = 0;

    cpu_fetch_sequencer #(
        .ADDR_WIDTH(32),
        .BOOT_ADDR (32'h0000_0100)
    ) dut (
        .i_clock           (clk),
        .i_reset           (reset),
        .o_icache_req_valid(req_valid),
        .i_icache_req_ready(req_ready),
        .o_icache_req_addr (req_addr),
        .i_icache_rsp_valid(rsp_valid),
        .i_icache_rsp_word (rsp_word),
        .i_redirect_valid  (redir_valid),
        .i_redirect_pc     (redir_pc),
        .i_stall           (stall),
        .o_decode_valid    (dec_valid),
        .o_decode_instr    (dec_instr),
        .o_decode_pc       (dec_pc),
        .o_decode_next_pc  (dec_next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle's inputs and move to the sampling point of that cycle.
    task automatic drive(input logic rdy, input logic rsp, input logic [31:0] word,
                         input logic rv, input logic [31:0] rpc, input logic stl);
        req_ready   = rdy;
        rsp_valid   = rsp;
        rsp_word    = word;
        redir_valid = rv;
        redir_pc    = rpc;
        stall       = stl;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_req(input string tag, input logic v, input logic [31:0] a);
        check_eq({tag, "_req_valid"}, {31'd0, req_valid}, {31'd0, v});
        if (v) check_eq({tag, "_req_addr"}, req_addr, a);
    endtask

    task automatic check_dec(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc, input logic [31:0] npc);
        check_eq({tag, "_dvalid"}, {31'd0, dec_valid}, 32'd1);
        check_eq({tag, "_dinstr"}, dec_instr, instr);
        check_eq({tag, "_dpc"}, dec_pc, pc);
        check_eq({tag, "_dnpc"}, dec_next_pc, npc);
    endtask

    initial begin
        reset = 1'b1;
        req_ready = 0; rsp_valid = 0; rsp_word = 0;
        redir_valid = 0; redir_pc = 0; stall = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Best-case flow from BOOT_ADDR
        drive(1, 0, 0, 0, 0, 0);
        check_req("rst", 1, 32'h100);
        check_eq("rst_dvalid", {31'd0, dec_valid}, 32'd0);
        check_eq("rst_dpc", dec_pc, 32'd0);
        next_cycle();
        drive(0, 1, 32'hA000_0001, 0, 0, 0);
        check_req("wait0", 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        check_dec("hold0", 32'hA000_0001, 32'h100, 32'h104);
        check_req("hold0", 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        check_req("req1", 1, 32'h104);
        check_eq("req1_dvalid", {31'd0, dec_valid}, 32'd0);
        next_cycle();
        drive(0, 1, 32'hA000_0002, 0, 0, 0);
        next_cycle();

        // Stall for 4 cycles: decode held 5 cycles, no request
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, (i < 4));
            check_dec("stall", 32'hA000_0002, 32'h104, 32'h108);
            check_req("stall", 0, 0);
            next_cycle();
        end
        drive(1, 0, 0, 0, 0, 0);
        check_req("req2", 1, 32'h108);
        check_eq("req2_dvalid", {31'd0, dec_valid}, 32'd0);
        next_cycle();

        // Redirect in S_WAIT, response 3 cycles later is squashed
        drive(0, 0, 0, 1, 32'h2003, 0);
        check_req("redir_wait", 0, 0);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            check_req("drop", 0, 0);
            next_cycle();
        end
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        check_req("drop_rsp", 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        check_eq("squash_dvalid", {31'd0, dec_valid}, 32'd0);
        check_req("after_drop", 1, 32'h2000);
        next_cycle();

        // Redirect coincident with response
        drive(0, 1, 32'hBAD0_0000, 1, 32'h3000, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        check_eq("coinc_dvalid", {31'd0, dec_valid}, 32'd0);
        check_req("coinc", 1, 32'h3000);
        next_cycle();
        drive(0, 1, 32'hA000_0003, 0, 0, 0);
        next_cycle();

        // Redirect in S_HOLD with stall asserted
        drive(0, 0, 0, 1, 32'h4000, 1);
        check_dec("hold_redir", 32'hA000_0003, 32'h3000, 32'h3004);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        check_eq("holdr_dvalid", {31'd0, dec_valid}, 32'd0);
        check_req("holdr", 1, 32'h4000);

        // Redirect while in S_REQ masks the request
        drive(1, 0, 0, 1, 32'hFFFF_FFFE, 0);
        check_req("req_redir", 0, 0);
        next_cycle();

        // Ready low 5 cycles: address stable
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            check_req("notready", 1, 32'hFFFF_FFFC);
            next_cycle();
        end
        drive(1, 0, 0, 0, 0, 0);
        check_req("accept", 1, 32'hFFFF_FFFC);
        next_cycle();
        drive(0, 1, 32'hA000_0004, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        check_dec("wrap", 32'hA000_0004, 32'hFFFF_FFFC, 32'h0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        check_req("wrap_req", 1, 32'h0);
        next_cycle();

        // Reset while in S_WAIT
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        reset = 1'b0;
        drive(0, 1, 32'hBAD1_0000, 0, 0, 0);
        check_eq("mrst_dvalid", {31'd0, dec_valid}, 32'd0);
        check_eq("mrst_dpc", dec_pc, 32'd0);
        check_eq("mrst_dinstr", dec_instr, 32'd0);
        check_req("mrst", 1, 32'h100);
        next_cycle();
        // Stale response above arrived in S_REQ and must have been ignored
        drive(1, 0, 0, 0, 0, 0);
        check_req("stale", 1, 32'h100);
        check_eq("stale_dvalid", {31'd0, dec_valid}, 32'd0);
        next_cycle();
        drive(0, 1, 32'hA000_0005, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        check_dec("post_rst", 32'hA000_0005, 32'h100, 32'h104);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_sequencer.md
# cpu_fetch_sequencer

Control block that sequences instruction fetch between the fetch PC, the instruction cache and the decode stage. It owns the architectural fetch PC and issues one instruction-cache request at a time. It waits for the response and presents the fetched word to decode, holding it under pipeline stall. Execute-stage branch redirects take priority over all of this; a response already in flight when a redirect arrives is squashed.

## Interface
Parameters:
- BOOT_ADDR, 32'h0000_0000, fetch PC value after reset
- ADDR_WIDTH, 32, PC/address width; instruction word is fixed at 32 bits

Ports:
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- icache_req_valid  out  1  request to instruction cache
- icache_req_ready  in  1  cache accepts request this cycle
- icache_req_addr  out  ADDR_WIDTH  request address (current PC)
- icache_rsp_valid  in  1  response word valid; responses are in order, one per accepted request
- icache_rsp_word  in  32  fetched instruction
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored and treated as 0
- stall  in  1  decode/execute cannot accept (includes multiply wait)
- decode_valid  out  1  decode_instr/pc/next_pc valid
- decode_instr  out  32  fetched instruction
- decode_pc  out  ADDR_WIDTH  address of decode_instr
- decode_next_pc  out  ADDR_WIDTH  decode_pc + 4

## Operation
- FSM states: S_REQ, S_WAIT, S_DROP, S_HOLD. At most one request outstanding.
- Combinational outputs:
  - icache_req_valid = (state==S_REQ) && !redirect_valid
  - icache_req_addr = pc
- All other outputs are registered.
- S_REQ:
  - redirect_valid: pc <= redirect_pc, stay in S_REQ.
  - Otherwise, on icache_req_ready: req_pc <= pc, go to S_WAIT.
- S_WAIT:
  - redirect_valid, with or without icache_rsp_valid: pc <= redirect_pc. With rsp, the response is discarded and the FSM goes to S_REQ. Without rsp, it goes to S_DROP.
  - rsp_valid alone: decode_instr <= word, decode_pc <= req_pc, decode_next_pc <= req_pc+4, decode_valid <= 1, pc <= req_pc+4, go to S_HOLD.
- S_DROP:
  - Wait for rsp_valid, discard it, then go to S_REQ.
  - Any redirect here updates pc (latest wins).
  - Redirect and rsp in the same cycle: pc <= redirect_pc, go to S_REQ.
- S_HOLD:
  - decode outputs are held stable while stall=1.
  - redirect_valid: decode_valid <= 0, pc <= redirect_pc, go to S_REQ. Redirect wins over stall.
  - stall=0 (consumed): decode_valid <= 0, go to S_REQ.
- icache_rsp_valid in S_REQ or S_HOLD is a protocol violation and is ignored (no state change).
- Arithmetic: pc+4 is modulo 2^ADDR_WIDTH. 0xFFFF_FFFC + 4 wraps to 0.
- Reset (any state, including mid-request):
  - state <= S_REQ, pc <= BOOT_ADDR
  - decode_valid <= 0, decode_instr/pc/next_pc <= 0
  - No squash bookkeeping survives reset; the cache is reset on the same reset.

## Timing
- Reset: icache_req_valid=1 with addr=BOOT_ADDR in the first cycle after reset deasserts.
- Best case (ready=1, 1-cycle rsp, stall=0):
  - C0: request accepted.
  - C1: rsp.
  - C2: decode_valid=1.
  - C3: next request (pc+4).
  - Throughput is one instruction per 3 cycles.
- decode_valid rises the cycle after the accepted rsp. It falls the cycle after the first cycle with stall=0, or after a redirect.
- Redirect to request latency: the redirect cycle updates pc; the request for redirect_pc is issued the next cycle when in S_REQ/S_WAIT-with-rsp/S_HOLD. From S_DROP, it is issued the cycle after the squashed rsp.
- icache_req_ready low: the request is held with a stable address until accepted or redirected.

## Test plan
- Reset, BOOT_ADDR=0x100, cache ready=1, 1-cycle latency, stall=0 -> requests at 0x100, 0x104, 0x108 on cycles 0, 3, 6; decode_pc/next_pc = 0x100/0x104, etc.
- Stall held 4 cycles while decode_valid=1 -> decode_instr/pc unchanged for 5 cycles; no icache_req_valid until the cycle after stall drops.
- Redirect to 0x2003 during S_WAIT, rsp 3 cycles later -> response not presented (decode_valid stays 0); next request addr 0x2000.
- Redirect coincident with rsp, and redirect during S_HOLD with stall=1 -> instruction dropped, decode_valid=0 next cycle, next request is redirect target.
- icache_req_ready low 5 cycles -> address stable at pc throughout; acceptance on cycle 6 then normal flow; PC 0xFFFFFFFC fetch gives decode_next_pc=0x0 and next request 0x0.
- Assert reset while in S_WAIT -> next cycle decode_valid=0, request at BOOT_ADDR; a stale rsp_valid arriving in S_REQ is ignored.
